// File: rtl/fx2_cmd_reader.sv
// fx2_cmd_reader: host-to-FPGA command path over the FX2 slave-FIFO bus.
// Reads bytes from FIFO2 whenever the bus is granted, parses them into
// register-write frames and emits one-cycle reg_wr strobes.
// Build option: define CMD_CHECKSUM_EN for 4-byte frames (SYNC,ADDR,DATA,CSUM);
// leave it undefined for 3-byte frames (SYNC,ADDR,DATA), timeout errors only.
module fx2_cmd_reader #(
  parameter int unsigned ADR_SETUP = 2,
  parameter int unsigned TIMEOUT   = 4096,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bus_grant,
  output logic       bus_busy,
  input  logic       FIFO2_data_available,
  input  logic [7:0] FIFO_DATAIN,
  output logic       FIFO_RD,
  output logic       FIFO_DATAIN_OE,
  output logic [1:0] FIFO_FIFOADR,
  output logic       reg_wr,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_data,
  output logic [7:0] err_cnt
);

  localparam int unsigned SW = (ADR_SETUP > 1) ? $clog2(ADR_SETUP) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {B_IDLE, B_SETUP, B_READ, B_GAP, B_RELEASE} bus_state_t;
  typedef enum logic [1:0] {P_HUNT, P_ADDR, P_DATA, P_CSUM} prs_state_t;

  bus_state_t bus_state, bus_nxt;
  prs_state_t prs_state, prs_nxt;

  logic [SW-1:0] setup_cnt;
  logic [TW-1:0] idle_cnt;
  logic [7:0]    addr_q;
  logic          capture;
  logic          frame_last;
  logic          good, bad, tmo;
  logic          busy_nxt, oe_nxt, rd_nxt;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] data_q;
  logic [7:0] csum_exp;
  assign csum_exp   = addr_q + data_q;
  assign frame_last = (prs_state == P_CSUM);
`else
  assign frame_last = (prs_state == P_DATA);
`endif

  // The FIFO is read in every B_READ cycle, so the byte lands at the edge ending it
  assign capture      = (bus_state == B_READ);
  assign FIFO_FIFOADR = 2'b00;

  // Bus and parser state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_state <= B_IDLE;
      prs_state <= P_HUNT;
    end else begin
      bus_state <= bus_nxt;
      prs_state <= prs_nxt;
    end
  end

  // Bus next state; the FIFO-empty decision is taken on entry to READ so that
  // the registered FIFO_RD is high for exactly the READ cycle.
  always_comb begin
    bus_nxt = bus_state;
    case (bus_state)
      B_IDLE:    if (FIFO2_data_available) bus_nxt = B_SETUP;
      B_SETUP:   if (setup_cnt == SW'(ADR_SETUP - 1))
                   bus_nxt = FIFO2_data_available ? B_READ : B_RELEASE;
      B_READ:    bus_nxt = frame_last ? B_RELEASE : B_GAP;
      B_GAP:     bus_nxt = FIFO2_data_available ? B_READ : B_RELEASE;
      B_RELEASE: bus_nxt = B_IDLE;
      default:   bus_nxt = B_IDLE;
    endcase
    if (!bus_grant) bus_nxt = B_IDLE;
  end

  // Bus outputs decoded from the next state, registered below
  always_comb begin
    busy_nxt = (bus_nxt != B_IDLE);
    oe_nxt   = (bus_nxt == B_SETUP) || (bus_nxt == B_READ) || (bus_nxt == B_GAP);
    rd_nxt   = (bus_nxt == B_READ);
  end

  // Registered bus outputs and FX2 address-setup counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_busy       <= 1'b0;
      FIFO_DATAIN_OE <= 1'b0;
      FIFO_RD        <= 1'b0;
      setup_cnt      <= '0;
    end else begin
      bus_busy       <= busy_nxt;
      FIFO_DATAIN_OE <= oe_nxt;
      FIFO_RD        <= rd_nxt;
      setup_cnt      <= (bus_state == B_SETUP) ? setup_cnt + 1'b1 : '0;
    end
  end

  // Parser next state plus frame-complete / error events
  always_comb begin
    prs_nxt = prs_state;
    good    = 1'b0;
    bad     = 1'b0;
    tmo     = 1'b0;
    if (capture) begin
      case (prs_state)
        P_HUNT: if (FIFO_DATAIN == SYNC_BYTE) prs_nxt = P_ADDR;
        P_ADDR: prs_nxt = P_DATA;
`ifdef CMD_CHECKSUM_EN
        P_DATA: prs_nxt = P_CSUM;
        P_CSUM: begin
          prs_nxt = P_HUNT;
          good    = (FIFO_DATAIN == csum_exp);
          bad     = (FIFO_DATAIN != csum_exp);
        end
`else
        P_DATA: begin
          prs_nxt = P_HUNT;
          good    = 1'b1;
        end
`endif
        default: prs_nxt = P_HUNT;
      endcase
    end else if ((prs_state != P_HUNT) && (idle_cnt == TW'(TIMEOUT - 1))) begin
      prs_nxt = P_HUNT;
      tmo     = 1'b1;
    end
  end

  // Frame capture, register-write strobe, error counter and inactivity timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= '0;
`ifdef CMD_CHECKSUM_EN
      data_q   <= '0;
`endif
      reg_wr   <= 1'b0;
      reg_addr <= '0;
      reg_data <= '0;
      err_cnt  <= '0;
      idle_cnt <= '0;
    end else begin
      reg_wr <= good;
      if (capture && (prs_state == P_ADDR)) addr_q <= FIFO_DATAIN;
`ifdef CMD_CHECKSUM_EN
      if (capture && (prs_state == P_DATA)) data_q <= FIFO_DATAIN;
      if (good) begin
        reg_addr <= addr_q;
        reg_data <= data_q;
      end
`else
      if (good) begin
        reg_addr <= addr_q;
        reg_data <= FIFO_DATAIN;
      end
`endif
      if ((bad || tmo) && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (capture || tmo || (prs_state == P_HUNT)) idle_cnt <= '0;
      else                                          idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fx2_cmd_reader.sv
// Directed bench for fx2_cmd_reader: an FX2 FIFO2 model feeds queued bytes,
// table-driven frames plus hand-written timeout, grant-drop, reset and
// error-saturation sequences. Expectations follow the CMD_CHECKSUM_EN build.
module tb_fx2_cmd_reader;

  localparam int unsigned TMO = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bus_grant = 1'b0;
  logic       bus_busy;
  logic       FIFO2_data_available = 1'b0;
  logic [7:0] FIFO_DATAIN = 8'h00;
  logic       FIFO_RD;
  logic       FIFO_DATAIN_OE;
  logic [1:0] FIFO_FIFOADR;
  logic       reg_wr;
  logic [7:0] reg_addr;
  logic [7:0] reg_data;
  logic [7:0] err_cnt;

  fx2_cmd_reader #(.ADR_SETUP(2), .TIMEOUT(TMO), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .bus_grant(bus_grant), .bus_busy(bus_busy),
    .FIFO2_data_available(FIFO2_data_available), .FIFO_DATAIN(FIFO_DATAIN),
    .FIFO_RD(FIFO_RD), .FIFO_DATAIN_OE(FIFO_DATAIN_OE), .FIFO_FIFOADR(FIFO_FIFOADR),
    .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_data(reg_data), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // FIFO2 model: stim_mem holds bytes the host has sent, rd_ptr is the FX2 read side
  logic [7:0]  stim_mem [0:4095];
  int unsigned stim_len = 0;
  int unsigned rd_ptr   = 0;
  int unsigned cyc      = 0;
  int unsigned pop_cyc [0:4095];
  bit          rd_prev = 1'b0, rd_double = 1'b0, was_rd;

  always @(posedge clk) begin
    was_rd = FIFO_RD;
    cyc++;
    if (was_rd && rd_prev) rd_double = 1'b1;
    rd_prev = was_rd;
    #1;
    if (was_rd) begin
      pop_cyc[rd_ptr] = cyc;
      rd_ptr++;
    end
    FIFO2_data_available = (rd_ptr < stim_len);
    FIFO_DATAIN = (rd_ptr < stim_len) ? stim_mem[rd_ptr] : 8'h00;
  end

  // reg_wr monitor
  int unsigned wr_cnt = 0;
  bit          wr_prev = 1'b0, wr_double = 1'b0;
  always @(negedge clk) begin
    if (reg_wr && wr_prev) wr_double = 1'b1;
    wr_prev = reg_wr;
    if (reg_wr) wr_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    stim_mem[stim_len] = b;
    stim_len++;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    @(negedge clk);
    while ((rd_ptr != stim_len || bus_busy) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 20000), 32'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_pops(input int unsigned target, input string name);
    int unsigned n = 0;
    while (rd_ptr < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n < 1000), 32'd1);
  endtask

  typedef struct {
    logic [47:0] b;    // first byte in [47:40]
    int unsigned n;
    int unsigned wr;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [7:0]  err;
  } vec_t;

  vec_t vecs [0:4];

`ifdef CMD_CHECKSUM_EN
  localparam logic [7:0] ERR_TABLE = 8'd2;
  localparam int unsigned FLEN     = 4;
`else
  localparam logic [7:0] ERR_TABLE = 8'd0;
  localparam int unsigned FLEN     = 3;
`endif

  initial begin
    int unsigned p0, w0;
    logic [7:0]  e0;
    logic [7:0]  bt;
    logic [31:0] sat_err [0:2];
    int unsigned sat_n   [0:2];
    int unsigned fidx;

`ifdef CMD_CHECKSUM_EN
    vecs[0] = '{48'hA5_12_34_46_00_00, 4, 1, 8'h12, 8'h34, 8'd0};
    vecs[1] = '{48'h00_FF_A5_12_34_00, 6, 0, 8'h12, 8'h34, 8'd1};
    vecs[2] = '{48'hA5_A5_A5_4A_00_00, 4, 1, 8'hA5, 8'hA5, 8'd1};
    vecs[3] = '{48'hA5_FF_01_00_00_00, 4, 1, 8'hFF, 8'h01, 8'd1};
    vecs[4] = '{48'hA5_10_20_31_00_00, 4, 0, 8'hFF, 8'h01, 8'd2};
    sat_err[0] = 32'hFE; sat_err[1] = 32'hFF; sat_err[2] = 32'hFF;
`else
    vecs[0] = '{48'hA5_12_34_00_00_00, 3, 1, 8'h12, 8'h34, 8'd0};
    vecs[1] = '{48'h00_FF_A5_12_34_00, 6, 1, 8'h12, 8'h34, 8'd0};
    vecs[2] = '{48'hA5_A5_A5_00_00_00, 3, 1, 8'hA5, 8'hA5, 8'd0};
    vecs[3] = '{48'hA5_FF_01_00_00_00, 3, 1, 8'hFF, 8'h01, 8'd0};
    vecs[4] = '{48'h77_A5_10_20_00_00, 4, 1, 8'h10, 8'h20, 8'd0};
    sat_err[0] = 32'h00; sat_err[1] = 32'h00; sat_err[2] = 32'h00;
`endif
    sat_n[0] = 254; sat_n[1] = 1; sat_n[2] = 45;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_busy_rd_oe", {bus_busy, FIFO_RD, FIFO_DATAIN_OE}, 3'b000);
    chk("rst_reg_wr", reg_wr, 1'b0);
    chk("rst_addr_data", {reg_addr, reg_data}, 16'h0000);
    chk("rst_err_cnt", err_cnt, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_grant = 1'b1;

    // Table-driven frames
    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt;
      p0 = rd_ptr;
      for (int k = 0; k < vecs[i].n; k++) begin
        bt = vecs[i].b[47 - 8*k -: 8];
        push(bt);
      end
      wait_drain("vec_drain");
      chk("vec_reg_wr_count", wr_cnt - w0, vecs[i].wr);
      chk("vec_reg_addr", reg_addr, vecs[i].addr);
      chk("vec_reg_data", reg_data, vecs[i].data);
      chk("vec_err_cnt", err_cnt, vecs[i].err);
      if (i == 0)
        for (int k = 0; k + 1 < vecs[i].n; k++)
          chk("rd_spacing", pop_cyc[p0 + k + 1] - pop_cyc[p0 + k], 32'd2);
    end

    // Inactivity timeout inside a frame
    e0 = err_cnt;
    chk("pre_tmo_err", e0, ERR_TABLE);
    p0 = rd_ptr;
    push(8'hA5); push(8'h07);
    wait_pops(p0 + 2, "tmo_pops");
    repeat (TMO - 4) @(negedge clk);
    chk("tmo_not_yet", err_cnt, e0);
    repeat (8) @(negedge clk);
    chk("tmo_err_cnt", err_cnt, e0 + 8'd1);
    w0 = wr_cnt;
    push(8'hA5); push(8'h01); push(8'h02); push(8'h03);
    wait_drain("tmo_drain");
    chk("tmo_reg_wr_count", wr_cnt - w0, 32'd1);
    chk("tmo_reg_addr_data", {reg_addr, reg_data}, 16'h0102);
    chk("tmo_err_after", err_cnt, e0 + 8'd1);

    // Grant dropped during GAP after the ADDR byte
    w0 = wr_cnt;
    p0 = rd_ptr;
    push(8'hA5); push(8'h12); push(8'h34); push(8'h46);
    wait_pops(p0 + 2, "gnt_pops");
    chk("gap_busy_oe_rd", {bus_busy, FIFO_DATAIN_OE, FIFO_RD}, 3'b110);
    chk("gap_fifoadr", FIFO_FIFOADR, 2'b00);
    bus_grant = 1'b0;
    @(posedge clk);
    #1;
    chk("ungrant_busy_oe_rd", {bus_busy, FIFO_DATAIN_OE, FIFO_RD}, 3'b000);
    repeat (6) @(negedge clk);
    chk("ungrant_no_reads", rd_ptr, p0 + 2);
    bus_grant = 1'b1;
    wait_drain("gnt_drain");
    chk("gnt_reg_wr_count", wr_cnt - w0, 32'd1);
    chk("gnt_reg_addr_data", {reg_addr, reg_data}, 16'h1234);

    // Async reset mid-frame, after the DATA byte
    p0 = rd_ptr;
    push(8'hA5); push(8'h12); push(8'h34);
    wait_pops(p0 + 3, "rst_pops");
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy_oe_rd", {bus_busy, FIFO_DATAIN_OE, FIFO_RD}, 3'b000);
    chk("midrst_outputs", {reg_wr, reg_addr, reg_data, err_cnt}, 25'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w0 = wr_cnt;
    push(8'h46); push(8'hA5); push(8'h12); push(8'h34); push(8'h46);
    wait_drain("rst_drain");
    chk("postrst_reg_wr_count", wr_cnt - w0, 32'd1);
    chk("postrst_reg_addr_data", {reg_addr, reg_data}, 16'h1234);
    chk("postrst_err_cnt", err_cnt, 8'h00);

    // Long frame streams: errors saturate with checksums, none without
    fidx = 0;
    for (int s = 0; s < 3; s++) begin
      w0 = wr_cnt;
      for (int f = 0; f < sat_n[s]; f++) begin
        push(8'hA5);
        bt = 8'(fidx);
        push(bt);
        push(8'h55);
        bt = 8'(fidx) + 8'h56;       // sum+1: always a bad checksum
        if (FLEN == 4) push(bt);
        fidx++;
      end
      wait_drain("stream_drain");
      chk("stream_err_cnt", err_cnt, sat_err[s]);
      chk("stream_reg_wr_count", wr_cnt - w0, (FLEN == 4) ? 32'd0 : 32'(sat_n[s]));
    end
    bt = 8'(fidx - 1);
    chk("stream_last_addr", reg_addr, (FLEN == 4) ? 8'h12 : bt);

    chk("fifo_rd_single_cycle", rd_double, 1'b0);
    chk("reg_wr_single_cycle", wr_double, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
